// File: rtl/dut_out_monitor.sv
// Return path of the TinyTapeout harness: samples the DUT io_out bus on rising
// edges of the divided DUT clock, queues values and ships them out as 8N1 UART.
module dut_out_monitor #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_AW      = 2,
  parameter bit          SEND_ALL     = 1'b0
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       clk_dut,
  input  logic [7:0] dut_out,
  input  logic       enable,
  output logic       uart_tx,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned      DEPTH     = 2 ** FIFO_AW;
  localparam int unsigned      BAUD_M1   = CLKS_PER_BIT - 1;
  localparam logic [FIFO_AW:0] FULL_CNT  = DEPTH[FIFO_AW:0];
  localparam logic [15:0]      BAUD_LAST = BAUD_M1[15:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  logic               clk_dut_q;
  logic               first_q, first_d;
  logic [7:0]         last_q, last_d;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  tx_state_e          state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;

  logic               sample_stb;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;

  // Sample strobe, change detection and last-value tracking.
  always_comb begin
    sample_stb = clk_dut & ~clk_dut_q & enable;
    push_req   = sample_stb & (SEND_ALL | first_q | (dut_out != last_q));
    first_d    = first_q;
    last_d     = last_q;
    if (sample_stb) begin
      first_d = 1'b0;
      last_d  = dut_out;
    end else begin
      first_d = first_q;
      last_d  = last_q;
    end
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot for a push while full.
  always_comb begin
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == {(FIFO_AW + 1){1'b0}});
    push_ok    = push_req & (~fifo_full | pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_req & fifo_full & ~pop) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // UART transmit FSM: next state, shifter, baud/bit counters and the tx bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = 16'd0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = 16'd0;
          tx_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // busy is registered from next-state values so it lines up with state and count.
  always_comb begin
    busy_d = (state_d != ST_IDLE) | (count_d != {(FIFO_AW + 1){1'b0}});
  end

  // State registers with synchronous reset; the edge detector tracks clk_dut even in reset.
  always_ff @(posedge CLK) begin
    clk_dut_q <= clk_dut;
    if (rst) begin
      first_q  <= 1'b1;
      last_q   <= 8'h00;
      wr_ptr_q <= {FIFO_AW{1'b0}};
      rd_ptr_q <= {FIFO_AW{1'b0}};
      count_q  <= {(FIFO_AW + 1){1'b0}};
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      first_q  <= first_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge CLK) begin
    if (push_ok && !rst) begin
      mem_q[wr_ptr_q] <= dut_out;
    end
  end

  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_dut_out_monitor.sv
// Directed bench: two monitor instances (default timing, and fast/send-all) with a
// byte scoreboard per instance checked by a UART frame decoder.
module tb_dut_out_monitor;

  localparam int CPB_A = 104;
  localparam int CPB_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, cd_a, en_a, tx_a, busy_a, ovf_a;
  logic [7:0] do_a;
  logic       rst_b, cd_b, en_b, tx_b, busy_b, ovf_b;
  logic [7:0] do_b;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int         frames[2];
  int         checks   = 0;
  int         failures = 0;

  dut_out_monitor #(.CLKS_PER_BIT(CPB_A), .FIFO_AW(2), .SEND_ALL(1'b0)) u_dut_a (
    .CLK(clk), .rst(rst_a), .clk_dut(cd_a), .dut_out(do_a), .enable(en_a),
    .uart_tx(tx_a), .busy(busy_a), .overflow(ovf_a)
  );

  dut_out_monitor #(.CLKS_PER_BIT(CPB_B), .FIFO_AW(2), .SEND_ALL(1'b1)) u_dut_b (
    .CLK(clk), .rst(rst_b), .clk_dut(cd_b), .dut_out(do_b), .enable(en_b),
    .uart_tx(tx_b), .busy(busy_b), .overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic rst_of(input int sel);
    return (sel == 0) ? rst_a : rst_b;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  function automatic int exp_size(input int sel);
    return (sel == 0) ? exp_a.size() : exp_b.size();
  endfunction

  function automatic logic [7:0] exp_pop(input int sel);
    if (sel == 0) return exp_a.pop_front();
    else return exp_b.pop_front();
  endfunction

  // Called on the negedge where the start bit was first seen; checks every bit cell.
  task automatic rx_frame(input int sel, input int cpb, output logic [7:0] d,
                          output bit ok, output bit ab);
    int slot;
    ok = 1'b1;
    ab = 1'b0;
    d  = 8'h00;
    for (int p = 1; p < 10 * cpb; p++) begin
      @(negedge clk);
      if (rst_of(sel) !== 1'b0) begin
        ab = 1'b1;
        return;
      end
      slot = p / cpb;
      if (slot == 0) begin
        if (tx_of(sel) !== 1'b0) ok = 1'b0;
      end else if (slot == 9) begin
        if (tx_of(sel) !== 1'b1) ok = 1'b0;
      end else if (p % cpb == 0) begin
        d[slot-1] = tx_of(sel);
      end else if (tx_of(sel) !== d[slot-1]) begin
        ok = 1'b0;
      end
    end
  endtask

  task automatic monitor(input int sel, input int cpb);
    logic [7:0] d, e;
    bit ok, ab, b2b;
    b2b = 1'b0;
    forever begin
      if (b2b) begin
        @(negedge clk);
        check($sformatf("gap_idle_%0d", sel), tx_of(sel), 1'b1);
        @(negedge clk);
        check($sformatf("gap_start_%0d", sel), tx_of(sel), 1'b0);
      end else begin
        do begin
          @(negedge clk);
        end while (rst_of(sel) !== 1'b0 || tx_of(sel) !== 1'b0);
      end
      rx_frame(sel, cpb, d, ok, ab);
      b2b = 1'b0;
      if (!ab) begin
        frames[sel]++;
        check($sformatf("frame_fmt_%0d", sel), ok, 1'b1);
        check($sformatf("frame_expected_%0d", sel), (exp_size(sel) != 0), 1'b1);
        if (exp_size(sel) != 0) begin
          e = exp_pop(sel);
          check($sformatf("frame_data_%0d", sel), d, e);
          b2b = (exp_size(sel) != 0);
        end
      end
    end
  endtask

  initial monitor(0, CPB_A);
  initial monitor(1, CPB_B);

  // One rising clk_dut edge: the strobe cycle is the one after the next posedge.
  task automatic pulse(input int sel, input logic [7:0] v);
    @(posedge clk); #1;
    if (sel == 0) begin cd_a = 1'b1; do_a = v; end
    else begin cd_b = 1'b1; do_b = v; end
    @(posedge clk); #1;
    if (sel == 0) cd_a = 1'b0;
    else cd_b = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int sel, input int max_cyc, input string tag);
    int n = 0;
    @(negedge clk);
    while (busy_of(sel) !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy_of(sel), 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    frames[0] = 0;
    frames[1] = 0;
    rst_a = 1'b1; cd_a = 1'b0; en_a = 1'b1; do_a = 8'hA5;
    rst_b = 1'b1; cd_b = 1'b0; en_b = 1'b1; do_b = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_a", tx_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_ovf_a", ovf_a, 1'b0);
    check("rst_tx_b", tx_b, 1'b1);
    check("rst_busy_b", busy_b, 1'b0);
    check("rst_ovf_b", ovf_b, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // First sample after reset, latency to start bit.
    exp_a.push_back(8'hA5);
    pulse(0, 8'hA5);
    @(negedge clk);
    check("lat_pop_cycle_tx", tx_a, 1'b1);
    check("lat_busy", busy_a, 1'b1);
    @(negedge clk);
    check("lat_start", tx_a, 1'b0);
    wait_idle(0, 1500, "a5_drain");
    check("a5_frames", frames[0], 1);

    // Unchanged value sent once, then a change.
    exp_a.push_back(8'h3C);
    for (int i = 0; i < 5; i++) begin
      pulse(0, 8'h3C);
      tick(3);
    end
    wait_idle(0, 1500, "same_drain");
    check("same_frames", frames[0], 2);
    exp_a.push_back(8'h3D);
    pulse(0, 8'h3D);
    wait_idle(0, 1500, "chg_drain");
    check("chg_frames", frames[0], 3);

    // enable=0: in-flight frame finishes, no new samples, last value frozen.
    exp_a.push_back(8'h11);
    pulse(0, 8'h11);
    tick(20);
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v = 8'h20 + 8'(i);
      pulse(0, v);
      tick(1);
    end
    wait_idle(0, 1500, "dis_drain");
    check("dis_frames", frames[0], 4);
    en_a = 1'b1;
    pulse(0, 8'h11);
    @(negedge clk);
    check("reen_no_push", busy_a, 1'b0);
    tick(10);
    @(negedge clk);
    check("reen_no_frame", busy_a, 1'b0);

    // Reset three bits into a frame, then first sample equal to the old value.
    exp_a.push_back(8'h00);
    pulse(0, 8'h00);
    tick(2 + 3 * CPB_A);
    rst_a = 1'b1;
    exp_a.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx", tx_a, 1'b1);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_ovf", ovf_a, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    exp_a.push_back(8'h00);
    pulse(0, 8'h00);
    wait_idle(0, 1500, "postrst_drain");
    check("postrst_frames", frames[0], 5);
    check("exp_a_empty", exp_a.size(), 0);

    // Fast instance: overflow with pushes every 3 cycles.
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) tick(1);
      v = 8'(i);
      if (i <= 5) exp_b.push_back(v);
      pulse(1, v);
      @(negedge clk);
      check($sformatf("ovf_step_%0d", i), ovf_b, (i >= 6));
    end
    wait_idle(1, 400, "ovf_drain");
    check("ovf_sticky", ovf_b, 1'b1);
    check("ovf_frames", frames[1], 5);
    rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovf_clr", ovf_b, 1'b0);
    @(posedge clk); #1;
    rst_b = 1'b0;

    // Full FIFO with push landing on the pop cycle; 12 bytes across pointer wrap.
    for (int i = 0; i < 12; i++) begin
      if (i >= 1 && i <= 4) tick(1);
      else if (i == 5) tick(28);
      else if (i > 5) tick(39);
      v = 8'h40 + 8'(i);
      exp_b.push_back(v);
      pulse(1, v);
      @(negedge clk);
      check($sformatf("wrap_ovf_%0d", i), ovf_b, 1'b0);
    end
    wait_idle(1, 400, "wrap_drain");
    check("wrap_frames", frames[1], 17);
    check("wrap_ovf_end", ovf_b, 1'b0);
    check("exp_b_empty", exp_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
